// File: rtl/fp_divsqrt_sched_if.sv
// Handshake bundle between the divide/sqrt requesters and the shared
// mantissa-engine scheduler. The scheduler takes the slave side; the
// requesters and the engine take the master side.
interface fp_divsqrt_sched_if;
  logic in_div_req;
  logic in_div_dp;
  logic in_sqrt_req;
  logic in_sqrt_dp;
  logic in_flush;
  logic out_load;
  logic out_shift_en;
  logic out_sel_sqrt;
  logic out_sel_dp;
  logic out_busy;
  logic out_div_done;
  logic out_sqrt_done;
  logic out_div_stall;
  logic out_sqrt_stall;

  modport slave (
    input  in_div_req, in_div_dp, in_sqrt_req, in_sqrt_dp, in_flush,
    output out_load, out_shift_en, out_sel_sqrt, out_sel_dp, out_busy,
    output out_div_done, out_sqrt_done, out_div_stall, out_sqrt_stall
  );

  modport master (
    output in_div_req, in_div_dp, in_sqrt_req, in_sqrt_dp, in_flush,
    input  out_load, out_shift_en, out_sel_sqrt, out_sel_dp, out_busy,
    input  out_div_done, out_sqrt_done, out_div_stall, out_sqrt_stall
  );
endinterface

// File: rtl/fp_divsqrt_sched.sv
// Scheduler for a mantissa engine shared by the FP divider and square root.
// Arbitrates the two requesters round-robin, sequences LOAD -> ITER -> DONE,
// and returns a one-cycle done pulse to the owner. in_flush kills any
// operation without a done pulse. Control outputs are registered from the
// next-state decode so they line up exactly with the state register.
module fp_divsqrt_sched #(
  parameter int ITER_S = 26,
  parameter int ITER_D = 55
) (
  input logic           in_Clk,
  input logic           in_Rst_N,
  fp_divsqrt_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter start values: the count runs N-1 down to 0, giving N ITER cycles.
  localparam logic [7:0] CNT_S = 8'(ITER_S - 1);
  localparam logic [7:0] CNT_D = 8'(ITER_D - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       owner_r;       // 1 = sqrt owns the engine
  logic       owner_nxt_s;
  logic       sel_dp_r;
  logic       sel_dp_nxt_s;
  logic       last_r;        // last granted requester, 1 = sqrt
  logic       last_nxt_s;
  logic       grant_sqrt_s;

  logic       load_nxt_s;
  logic       shift_nxt_s;
  logic       busy_nxt_s;
  logic       div_done_nxt_s;
  logic       sqrt_done_nxt_s;
  logic       load_r;
  logic       shift_r;
  logic       busy_r;
  logic       div_done_r;
  logic       sqrt_done_r;

  // Round-robin arbiter: a lone request wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_sqrt_s = 1'b0;
    if (bus.in_div_req && bus.in_sqrt_req) begin
      grant_sqrt_s = ~last_r;
    end else if (bus.in_sqrt_req) begin
      grant_sqrt_s = 1'b1;
    end else begin
      grant_sqrt_s = 1'b0;
    end
  end

  // State register plus the operation context latched on each grant.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 8'd0;
      owner_r  <= 1'b0;
      sel_dp_r <= 1'b0;
      last_r   <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      owner_r  <= owner_nxt_s;
      sel_dp_r <= sel_dp_nxt_s;
      last_r   <= last_nxt_s;
    end
  end

  // Next-state logic; flush overrides every state and the pointer is never rolled back.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    owner_nxt_s  = owner_r;
    sel_dp_nxt_s = sel_dp_r;
    last_nxt_s   = last_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.in_flush && (bus.in_div_req || bus.in_sqrt_req)) begin
          state_nxt_s  = ST_LOAD;
          owner_nxt_s  = grant_sqrt_s;
          last_nxt_s   = grant_sqrt_s;
          sel_dp_nxt_s = grant_sqrt_s ? bus.in_sqrt_dp : bus.in_div_dp;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.in_flush) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ITER;
          cnt_nxt_s   = sel_dp_r ? CNT_D : CNT_S;
        end
      end
      ST_ITER: begin
        if (bus.in_flush) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 8'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ITER;
          cnt_nxt_s   = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs match the state register.
  always_comb begin
    load_nxt_s      = 1'b0;
    shift_nxt_s     = 1'b0;
    busy_nxt_s      = 1'b0;
    div_done_nxt_s  = 1'b0;
    sqrt_done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_LOAD: begin
        load_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_ITER: begin
        shift_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      ST_DONE: begin
        busy_nxt_s      = 1'b1;
        div_done_nxt_s  = ~owner_nxt_s;
        sqrt_done_nxt_s = owner_nxt_s;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output register stage for the engine strobes and the completion pulses.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      load_r      <= 1'b0;
      shift_r     <= 1'b0;
      busy_r      <= 1'b0;
      div_done_r  <= 1'b0;
      sqrt_done_r <= 1'b0;
    end else begin
      load_r      <= load_nxt_s;
      shift_r     <= shift_nxt_s;
      busy_r      <= busy_nxt_s;
      div_done_r  <= div_done_nxt_s;
      sqrt_done_r <= sqrt_done_nxt_s;
    end
  end

  assign bus.out_load       = load_r;
  assign bus.out_shift_en   = shift_r;
  assign bus.out_busy       = busy_r;
  assign bus.out_div_done   = div_done_r;
  assign bus.out_sqrt_done  = sqrt_done_r;
  assign bus.out_sel_sqrt   = owner_r;
  assign bus.out_sel_dp     = sel_dp_r;
  // Stall releases in the very cycle the requester sees its done pulse.
  assign bus.out_div_stall  = bus.in_div_req & ~div_done_r;
  assign bus.out_sqrt_stall = bus.in_sqrt_req & ~sqrt_done_r;

endmodule

// File: tb/tb_fp_divsqrt_sched.sv
// Scoreboard bench for fp_divsqrt_sched: directed stimulus pushes the
// expected completion of each granted operation; a negedge monitor pops and
// compares whenever a done pulse appears.
module tb_fp_divsqrt_sched;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct packed {
    logic sqrt;
    logic dp;
    int   n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_shifts;
  int   mon_load_cyc;
  int   e_cyc;

  fp_divsqrt_sched_if bus0 ();
  fp_divsqrt_sched_if bus1 ();

  fp_divsqrt_sched u_dut (
    .in_Clk   (clk),
    .in_Rst_N (rst_n),
    .bus      (bus0)
  );

  fp_divsqrt_sched #(.ITER_S(1)) u_dut1 (
    .in_Clk   (clk),
    .in_Rst_N (rst_n),
    .bus      (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_shifts = 0;
    end else begin
      chk("load_shift_exclusive", bus0.out_load & bus0.out_shift_en, 0);
      chk("single_done", bus0.out_div_done & bus0.out_sqrt_done, 0);
      if (bus0.out_load) begin
        mon_shifts   = 0;
        mon_load_cyc = cyc;
      end
      if (bus0.out_shift_en) mon_shifts++;
      if (bus0.out_div_done || bus0.out_sqrt_done) begin
        chk("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("done_owner_sqrt", bus0.out_sqrt_done, mon_e.sqrt);
          chk("done_owner_div", bus0.out_div_done, !mon_e.sqrt);
          chk("sel_sqrt", bus0.out_sel_sqrt, mon_e.sqrt);
          chk("sel_dp", bus0.out_sel_dp, mon_e.dp);
          chk("shift_cycles", mon_shifts, mon_e.n);
          chk("load_to_done", cyc - mon_load_cyc, mon_e.n + 1);
          chk("owner_stall_low", mon_e.sqrt ? bus0.out_sqrt_stall : bus0.out_div_stall, 0);
          chk("busy_in_done", bus0.out_busy, 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      got = bus0.out_div_done | bus0.out_sqrt_done;
    end
    chk({name, "_done_seen"}, got, 1);
  endtask

  task automatic wait_load(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      got = bus0.out_load;
    end
    chk({name, "_load_seen"}, got, 1);
  endtask

  task automatic push(input logic sq, input logic dp, input int n);
    exp_t e;
    e.sqrt = sq;
    e.dp   = dp;
    e.n    = n;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_load"}, bus0.out_load, 0);
    chk({name, "_shift"}, bus0.out_shift_en, 0);
    chk({name, "_busy"}, bus0.out_busy, 0);
    chk({name, "_div_done"}, bus0.out_div_done, 0);
    chk({name, "_sqrt_done"}, bus0.out_sqrt_done, 0);
    chk({name, "_sel_sqrt"}, bus0.out_sel_sqrt, 0);
    chk({name, "_sel_dp"}, bus0.out_sel_dp, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int shifts1;
    int dones1;
    int loads1;
    int sdones1;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus0.in_div_req  = 1'b0;
    bus0.in_div_dp   = 1'b0;
    bus0.in_sqrt_req = 1'b0;
    bus0.in_sqrt_dp  = 1'b0;
    bus0.in_flush    = 1'b0;
    bus1.in_div_req  = 1'b0;
    bus1.in_div_dp   = 1'b0;
    bus1.in_sqrt_req = 1'b0;
    bus1.in_sqrt_dp  = 1'b0;
    bus1.in_flush    = 1'b0;

    // Reset state, stall follows the request even while in reset.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    chk("reset_div_stall_idle", bus0.out_div_stall, 0);
    bus0.in_div_req = 1'b1;
    @(negedge clk);
    chk("reset_div_stall_req", bus0.out_div_stall, 1);
    chk("reset_sqrt_stall", bus0.out_sqrt_stall, 0);
    chk("reset_busy_req", bus0.out_busy, 0);
    bus0.in_div_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Single-precision divide with latency from the sampling edge.
    bus0.in_div_req = 1'b1;
    bus0.in_div_dp  = 1'b0;
    push(1'b0, 1'b0, 26);
    e_cyc = cyc + 1;
    wait_done("div_sp", 100);
    chk("div_sp_latency", cyc - e_cyc + 1, 28);
    chk("div_sp_stall_in_done", bus0.out_div_stall, 0);
    step();
    bus0.in_div_req = 1'b0;

    // Double-precision square root.
    step();
    bus0.in_sqrt_req = 1'b1;
    bus0.in_sqrt_dp  = 1'b1;
    push(1'b1, 1'b1, 55);
    wait_load("sqrt_dp", 10);
    chk("sqrt_dp_sel_sqrt", bus0.out_sel_sqrt, 1);
    chk("sqrt_dp_sel_dp", bus0.out_sel_dp, 1);
    wait_done("sqrt_dp", 100);
    step();
    bus0.in_sqrt_req = 1'b0;
    bus0.in_sqrt_dp  = 1'b0;

    // Both requesting continuously: strict alternation starting with div.
    step();
    bus0.in_div_req  = 1'b1;
    bus0.in_sqrt_req = 1'b1;
    push(1'b0, 1'b0, 26);
    push(1'b1, 1'b0, 26);
    push(1'b0, 1'b0, 26);
    push(1'b1, 1'b0, 26);
    for (int i = 0; i < 4; i++) wait_done("rr", 60);
    step();
    bus0.in_div_req  = 1'b0;
    bus0.in_sqrt_req = 1'b0;

    // Flush held in IDLE blocks any grant.
    step();
    bus0.in_flush   = 1'b1;
    bus0.in_div_req = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("flush_idle_busy", bus0.out_busy, 0);
    chk("flush_idle_load", bus0.out_load, 0);
    step();
    bus0.in_flush   = 1'b0;
    bus0.in_div_req = 1'b0;

    // Flush in the 10th ITER cycle of a divide; the held request restarts it.
    step();
    bus0.in_div_req = 1'b1;
    push(1'b0, 1'b0, 26);
    wait_load("flush_div", 10);
    repeat (10) step();
    chk("flush_in_iter", bus0.out_shift_en, 1);
    bus0.in_flush = 1'b1;
    step();
    bus0.in_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", bus0.out_busy, 0);
    chk("flush_div_done", bus0.out_div_done, 0);
    chk("flush_shift", bus0.out_shift_en, 0);
    wait_done("flush_restart", 100);
    step();
    bus0.in_div_req = 1'b0;

    // Reset during sqrt ITER, then a tie after reset goes to div.
    step();
    bus0.in_sqrt_req = 1'b1;
    bus0.in_sqrt_dp  = 1'b1;
    wait_load("rst_sqrt", 10);
    repeat (5) step();
    rst_n = 1'b0;
    bus0.in_sqrt_req = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    chk("rst_mid_div_stall", bus0.out_div_stall, 0);
    chk("rst_mid_sqrt_stall", bus0.out_sqrt_stall, 0);
    bus0.in_div_req  = 1'b1;
    bus0.in_div_dp   = 1'b0;
    bus0.in_sqrt_req = 1'b1;
    bus0.in_sqrt_dp  = 1'b1;
    push(1'b0, 1'b0, 26);
    push(1'b1, 1'b1, 55);
    @(negedge clk);
    chk("rst_req_busy", bus0.out_busy, 0);
    chk("rst_req_div_stall", bus0.out_div_stall, 1);
    step();
    rst_n = 1'b1;
    wait_done("rst_tie_first", 60);
    wait_done("rst_tie_second", 100);
    step();
    bus0.in_div_req  = 1'b0;
    bus0.in_sqrt_req = 1'b0;
    bus0.in_sqrt_dp  = 1'b0;

    // Precision change mid-operation has no effect.
    step();
    bus0.in_div_req = 1'b1;
    bus0.in_div_dp  = 1'b0;
    push(1'b0, 1'b0, 26);
    wait_load("dp_change", 10);
    repeat (3) step();
    bus0.in_div_dp = 1'b1;
    wait_done("dp_change", 60);
    step();
    bus0.in_div_req = 1'b0;
    bus0.in_div_dp  = 1'b0;

    // Request dropped mid-operation still completes.
    step();
    bus0.in_sqrt_req = 1'b1;
    push(1'b1, 1'b0, 26);
    wait_load("drop_req", 10);
    repeat (4) step();
    bus0.in_sqrt_req = 1'b0;
    wait_done("drop_req", 60);

    // ITER_S = 1 instance: exactly one shift cycle.
    step();
    shifts1 = 0;
    dones1  = 0;
    loads1  = 0;
    sdones1 = 0;
    bus1.in_div_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      shifts1 += int'(bus1.out_shift_en);
      loads1  += int'(bus1.out_load);
      dones1  += int'(bus1.out_div_done);
      sdones1 += int'(bus1.out_sqrt_done);
      if (bus1.out_div_done) begin
        step();
        bus1.in_div_req = 1'b0;
      end
    end
    chk("iter1_shift_cycles", shifts1, 1);
    chk("iter1_loads", loads1, 1);
    chk("iter1_div_dones", dones1, 1);
    chk("iter1_sqrt_dones", sdones1, 0);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_sched.md
FP_DIVSQRT_SCHED -- requirements
Module: fp_divsqrt_sched

Interface
REQ-001 Parameter ITER_S, default 26, SHALL set the shift-iteration count for single-precision operations (legal 1..255).
REQ-002 Parameter ITER_D, default 55, SHALL set the shift-iteration count for double-precision operations (legal 1..255).
REQ-003 in_Clk  input  1  clock; all state updates on rising edge.
REQ-004 in_Rst_N  input  1  reset, asynchronous, active-low.
REQ-005 in_div_req  input  1  divide requester wants the shared mantissa engine; held high until its done.
REQ-006 in_div_dp  input  1  divide precision, 1 = double.
REQ-007 in_sqrt_req  input  1  square-root requester wants the engine; held high until its done.
REQ-008 in_sqrt_dp  input  1  square-root precision, 1 = double.
REQ-009 in_flush  input  1  pipeline kill; aborts any operation.
REQ-010 out_load  output  1  engine operand load strobe.
REQ-011 out_shift_en  output  1  engine iteration enable.
REQ-012 out_sel_sqrt  output  1  engine mode/operand mux select, 1 = sqrt owner.
REQ-013 out_sel_dp  output  1  latched precision of the current operation.
REQ-014 out_busy  output  1  engine not idle.
REQ-015 out_div_done / out_sqrt_done  output  1 each  one-cycle completion pulse to the owner.
REQ-016 out_div_stall / out_sqrt_stall  output  1 each  stall to the respective requester.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, ITER, DONE, encoded in a state register with 8-bit iteration counter cnt.
REQ-018 IDLE: if in_flush = 0 and any request is high, next state SHALL be LOAD; otherwise remain IDLE.
REQ-019 Arbitration on IDLE->LOAD: single request wins; both high -> grant the requester not in last-owner pointer (round robin); pointer updates to the winner on every LOAD entry.
REQ-020 On IDLE->LOAD the block SHALL latch owner (-> out_sel_sqrt) and owner's dp bit (-> out_sel_dp); both held constant until next LOAD.
REQ-021 LOAD: out_load = 1 for exactly one cycle; cnt loaded with (sel_dp ? ITER_D : ITER_S) - 1; next state ITER.
REQ-022 ITER: out_shift_en = 1 every cycle; cnt decrements; when cnt = 0 next state DONE; exactly ITER_x ITER cycles per operation.
REQ-023 DONE: owner's done output = 1 for exactly one cycle; other done = 0; next state IDLE unconditionally.
REQ-024 Latency: request first sampled at edge E -> LOAD in cycle E..E+1, done high in cycle ITER_x+2 after E.
REQ-025 out_busy SHALL be 1 in LOAD, ITER and DONE, 0 in IDLE.
REQ-026 out_x_stall SHALL be combinational: in_x_req AND NOT out_x_done.
REQ-027 in_flush = 1 in any state SHALL force next state IDLE; no done pulse is produced for the aborted operation; round-robin pointer not rolled back.
REQ-028 A request dropped mid-operation SHALL NOT abort; operation completes and done still pulses.
REQ-029 Precision input changes after LOAD entry SHALL have no effect on the running operation.
REQ-030 out_load and out_shift_en SHALL never be high in the same cycle; at most one done high per cycle.

Reset
REQ-031 in_Rst_N low SHALL immediately force state IDLE, cnt = 0, owner = div, sel_dp = 0, last-owner pointer = sqrt (div wins first tie).
REQ-032 During and after reset, until a request: out_load, out_shift_en, out_busy, both done = 0; stall outputs follow REQ-026.
REQ-033 Reset asserted mid-ITER SHALL abort without done pulse; first post-reset tie SHALL grant div.

Verification
REQ-034 div_req=1, div_dp=0, defaults -> 1 load cycle, 26 shift_en cycles, div_done at cycle 28 after sampling edge, div_stall low in that cycle.
REQ-035 sqrt_req=1, sqrt_dp=1 -> sel_sqrt=1, sel_dp=1, 55 shift_en cycles, single sqrt_done pulse; div_done stays 0.
REQ-036 Both requests high continuously after reset -> grant order div, sqrt, div, sqrt; each done exactly one pulse per grant.
REQ-037 in_flush pulse at 10th ITER cycle of a div -> IDLE next cycle, no div_done, busy=0; held div_req restarts with new LOAD.
REQ-038 in_Rst_N low during sqrt ITER, then both requests -> all outputs 0 during reset, div granted first.
REQ-039 Change div_dp 0->1 during ITER -> shift_en count remains 26; ITER_S=1 override -> exactly 1 shift_en cycle.
